// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: D/E-side initiator for the multiply/divide unit.
// Issues MDUOp/MTHILO pulses, tracks MDU latency and stalls D.
module md_issue_ctrl #(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        d_valid,
  input  logic [3:0]  d_op,
  input  logic [1:0]  d_mthilo,
  input  logic [1:0]  d_mfhilo,
  input  logic [31:0] d_a,
  input  logic [31:0] d_b,
  input  logic [31:0] mdu_hi,
  input  logic [31:0] mdu_lo,
  input  logic        mdu_busy,
  output logic        stall,
  output logic [3:0]  md_op,
  output logic [1:0]  md_mthilo,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  output logic        md_clr,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        sync_err
);

  if (MUL_LAT < 1 || MUL_LAT > 15) begin : g_bad_mul
    $error("MUL_LAT must be 1..15");
  end
  if (DIV_LAT < 1 || DIV_LAT > 15) begin : g_bad_div
    $error("DIV_LAT must be 1..15");
  end

  localparam logic [3:0] OP_NONE = 4'hf;
  localparam logic [3:0] MUL_CNT = 4'(MUL_LAT);
  localparam logic [3:0] DIV_CNT = 4'(DIV_LAT);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    BUSY
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [3:0] cnt;
  logic [3:0] op_q;
  logic [1:0] mt_q;
  logic       flush_q;
  logic       accept;
  logic       acc_op;
  logic       acc_mt;
  logic       acc_mf;
  logic       is_div;
  logic       arith_q;

  // Priority op > mt > mf when decode sets more than one.
  assign accept = d_valid & (state == IDLE) & ~flush;
  assign acc_op = accept & (d_op != OP_NONE);
  assign acc_mt = accept & (d_op == OP_NONE)
                & (d_mthilo != 2'b00);
  assign acc_mf = accept & (d_op == OP_NONE)
                & (d_mthilo == 2'b00)
                & (d_mfhilo != 2'b00);

  assign arith_q = (op_q != OP_NONE);
  assign is_div  = (op_q[3:1] == 3'b001);

  assign stall  = d_valid & (state != IDLE) & ~flush;
  assign md_clr = flush;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (acc_op | acc_mt) state_nx = ISSUE;
        ISSUE:   state_nx = arith_q ? BUSY : IDLE;
        BUSY:    if (cnt == 4'd1) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    md_op     = OP_NONE;
    md_mthilo = 2'b00;
    if (state == ISSUE) begin
      md_op     = op_q;
      md_mthilo = mt_q;
    end
  end

  // Counter holds the remaining BUSY cycles, loaded as ISSUE ends.
  always_ff @(posedge clk) begin
    if (reset || flush)
      cnt <= '0;
    else if (state == ISSUE && arith_q)
      cnt <= is_div ? DIV_CNT : MUL_CNT;
    else if (state == BUSY)
      cnt <= cnt - 4'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q     <= OP_NONE;
      mt_q     <= 2'b00;
      md_a     <= '0;
      md_b     <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      flush_q  <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      rd_valid <= acc_mf;
      flush_q  <= flush;
      if (!flush && !flush_q
          && (mdu_busy != (state == BUSY)))
        sync_err <= 1'b1;
      if (acc_op) begin
        op_q <= d_op;
        mt_q <= 2'b00;
        md_a <= d_a;
        md_b <= d_b;
      end else if (acc_mt) begin
        op_q <= OP_NONE;
        mt_q <= d_mthilo;
        md_a <= d_a;
      end
      if (acc_mf)
        rd_data <= d_mfhilo[1] ? mdu_hi : mdu_lo;
    end
  end

endmodule
